// File: rtl/muldiv_sequencer.sv
// Iterative RV32M mul/div unit: 33 cycles start-to-done, 1 cycle for divide-by-zero/overflow.
// No input handshake: stall freezes the pipeline while iterating; start is sampled only in IDLE.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opb;

  logic                a_signed, b_signed, a_neg, b_neg, sign_in;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_res;

  always_comb begin
    a_signed = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2) ||
               (func3 == 3'd4) || (func3 == 3'd6);
    b_signed = (func3 == 3'd0) || (func3 == 3'd1) ||
               (func3 == 3'd4) || (func3 == 3'd6);
    a_neg    = a_signed & rs1[XLEN-1];
    b_neg    = b_signed & rs2[XLEN-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
    // Remainders take the dividend's sign; products and quotients take the XOR.
    sign_in  = (func3[2] & func3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = func3[2] & (rs2 == '0);
    div_ovf  = func3[2] & ~func3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = func3[1] ? rs1 : '1;
    else          special_res = func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_rem;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_fix;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    // Shifted partial remainder can reach XLEN+1 bits before the trial subtract.
    div_rem  = acc[2*XLEN-1:XLEN-1];
    div_diff = {1'b0, div_rem} - {2'b00, opb};
    div_nxt  = div_diff[XLEN+1] ? {div_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_nxt  = op_q[2] ? div_nxt : mul_nxt;
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_fix  = neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:             res_fix = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res_fix = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res_fix = quo_fix;
      default:          res_fix = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_q  <= func3;
            neg_q <= sign_in;
            cnt   <= '0;
            if (special) begin
              result <= special_res;
              state  <= S_DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, a_mag};
              opb   <= b_mag;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) begin
              result <= res_fix;
              state  <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall = ((state == S_IDLE) && start && !flush) || (state == S_RUN);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model plus per-cycle output compare.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2;
  logic        stall, busy, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else r = 32'(int'(a) / int'(b));
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else r = 32'(int'(a) % int'(b));
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Timing model: cycles of iteration left, a one-cycle done flag, and the visible result.
  int          m_left   = 0;
  bit          m_done   = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   = 0;
      m_done   = 1'b0;
      m_result = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      if (flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_result = m_pend;
        end
      end
    end else if (start && !flush) begin
      if (is_special(func3, rs1, rs2)) begin
        m_done   = 1'b1;
        m_result = ref_op(func3, rs1, rs2);
      end else begin
        m_left = 32;
        m_pend = ref_op(func3, rs1, rs2);
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    bit idle;
    if (cmp_en) begin
      idle = (m_left == 0) && !m_done;
      check("stall", 64'(stall), 64'((idle && start && !flush) || (m_left > 0)));
      check("busy", 64'(busy), 64'(!idle));
      check("done", 64'(done), 64'(m_done));
      check("result", 64'(result), 64'(m_result));
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] exp, input string name);
    int n;
    int sc;
    bit seen;
    @(posedge clk); #2;
    start = 1'b1; func3 = f; rs1 = a; rs2 = b;
    @(negedge clk);
    sc = stall ? 1 : 0;
    @(posedge clk); #2;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (stall) sc++;
      if (done) seen = 1'b1;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_stall_cycles"}, 64'(sc), 64'(lat));
    check({name, "_result"}, 64'(result), 64'(exp));
    @(negedge clk);
    check({name, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dcount;
    rst_n = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; rs1 = '0; rs2 = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_result", 64'(result), 64'(0));

    check("model_mulhu", 64'(ref_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'h0FFFFFFFE);
    check("model_mulh", 64'(ref_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'h0);
    check("model_div", 64'(ref_op(3'd4, 32'hFFFFFFF9, 32'd2)), 64'h0FFFFFFFD);
    check("model_rem", 64'(ref_op(3'd6, 32'hFFFFFFF9, 32'd2)), 64'h0FFFFFFFF);

    @(posedge clk); #2;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFEB, "mul");
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, "mulhu");
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000, "mulh");
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, 33, 32'hFFFFFFFF, "mulhsu");
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, "div");
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, "rem");
    do_op(3'd5, 32'd100, 32'd7, 33, 32'd14, "divu");
    do_op(3'd7, 32'd100, 32'd7, 33, 32'd2, "remu");
    do_op(3'd5, 32'h1234, 32'd0, 1, 32'hFFFFFFFF, "divu_zero");
    do_op(3'd6, 32'h1234, 32'd0, 1, 32'h00001234, "rem_zero");

    // Flush partway through a multiply: no done, result keeps 0x1234.
    @(posedge clk); #2;
    start = 1'b1; func3 = 3'd0; rs1 = 32'd9; rs2 = 32'd11;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("flush_no_done", 64'(dcount), 64'(0));
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_result_kept", 64'(result), 64'h1234);

    do_op(3'd0, 32'd3, 32'd5, 33, 32'd15, "mul_after_flush");
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, "div_ovf");
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, "rem_ovf");
    do_op(3'd0, 32'd3, 32'd5, 33, 32'd15, "mul_nonzero");

    // Asynchronous reset between edges in the middle of an iteration.
    @(posedge clk); #2;
    start = 1'b1; func3 = 3'd5; rs1 = 32'd12345; rs2 = 32'd17;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_stall", 64'(stall), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_result", 64'(result), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Back-to-back: start held high across DONE, operands switched in the following IDLE cycle.
    @(posedge clk); #2;
    start = 1'b1; func3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7;
    dcount = 0; n = 0;
    while (dcount < 1 && n < 50) begin
      @(negedge clk); n++;
      if (done) dcount++;
    end
    check("b2b_mul_result", 64'(result), 64'd42);
    @(posedge clk); #2;
    func3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    n = 0;
    while (dcount < 2 && n < 50) begin
      @(negedge clk); n++;
      if (done) dcount++;
    end
    check("b2b_divu_result", 64'(result), 64'd14);
    @(posedge clk); #2;
    start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("b2b_done_count", 64'(dcount), 64'd2);

    // Randomized traffic: mixed ops, special operands, held starts and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      int mode;
      @(posedge clk); #2;
      start = ($urandom_range(0, 3) != 0);
      func3 = 3'($urandom_range(0, 7));
      mode  = $urandom_range(0, 9);
      case (mode)
        0: begin rs1 = $urandom; rs2 = 32'd0; end
        1: begin rs1 = 32'h80000000; rs2 = 32'hFFFFFFFF; end
        2: begin rs1 = 32'($urandom_range(0, 300)); rs2 = 32'($urandom_range(1, 20)); end
        3: begin rs1 = -32'($urandom_range(0, 300)); rs2 = -32'($urandom_range(1, 20)); end
        default: begin rs1 = $urandom; rs2 = $urandom; end
      endcase
      flush = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0;
    repeat (40) @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
